// File: rtl/alu_mc_if.sv
// ----------------------------------------------------------------------------
// alu_mc_if : operation/result handshake bundle for the multi-cycle ALU.
//
// Signals
//   flush          synchronous abort of any in-flight or held operation
//   in_valid       operation request            (master -> slave)
//   in_ready       ALU can accept an operation  (slave  -> master)
//   alu_ops        opcode                       (master -> slave)
//   operand_a      rs1 value                    (master -> slave)
//   operand_b      rs2 / immediate value        (master -> slave)
//   out_valid      result valid                 (slave  -> master)
//   out_ready      consumer accepts the result  (master -> slave)
//   alu_output     computational result         (slave  -> master)
//   branch_output  branch-compare result        (slave  -> master)
//   busy           iterating in SHIFT or MUL    (slave  -> master)
// ----------------------------------------------------------------------------
interface alu_mc_if #(
   parameter int XLEN = 32,
   parameter int OP_W = 5
);
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [OP_W-1:0] alu_ops;
   logic [XLEN-1:0] operand_a;
   logic [XLEN-1:0] operand_b;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] alu_output;
   logic            branch_output;
   logic            busy;

   modport slave (
      input  flush, in_valid, alu_ops, operand_a, operand_b, out_ready,
      output in_ready, out_valid, alu_output, branch_output, busy
   );

   modport master (
      output flush, in_valid, alu_ops, operand_a, operand_b, out_ready,
      input  in_ready, out_valid, alu_output, branch_output, busy
   );
endinterface

// File: rtl/alu_mc.sv
// ----------------------------------------------------------------------------
// alu_mc : multi-cycle ALU between register read and writeback/PC-select.
//
// Accepts one operation per in_valid/in_ready handshake, computes it (single
// cycle, or iteratively for shifts and the optional multiply) and holds the
// result with out_valid until out_ready is seen.
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    alu_mc_if.slave (request, operands, result, flush, busy)
//
// Parameters
//   XLEN        operand/result width (power of two, >= 8)
//   SHIFT_STEP  bit positions shifted / multiplier bits consumed per cycle
//   OP_W        opcode width
//
// Optional feature macro: ALU_MC_MUL_EN (opcode 17 = MUL via shift-add).
// ----------------------------------------------------------------------------
module alu_mc #(
   parameter int XLEN       = 32,
   parameter int SHIFT_STEP = 1,
   parameter int OP_W       = 5
) (
   input logic     clk,
   input logic     rst_n,
   alu_mc_if.slave bus
);

   // state  | meaning
   // -------+-----------------------------------------------------------
   // IDLE   | in_ready=1, waiting for an operation
   // SHIFT  | iterating a shift, SHIFT_STEP positions per cycle
   // MUL    | iterating shift-add multiply (ALU_MC_MUL_EN builds only)
   // DONE   | out_valid=1, result held until out_ready

   localparam int SH_W  = $clog2(XLEN);
   localparam int CNT_W = SH_W + 1;

   localparam logic [OP_W-1:0] OP_ADD  = OP_W'(0);
   localparam logic [OP_W-1:0] OP_SUB  = OP_W'(1);
   localparam logic [OP_W-1:0] OP_SLL  = OP_W'(2);
   localparam logic [OP_W-1:0] OP_SRL  = OP_W'(3);
   localparam logic [OP_W-1:0] OP_SRA  = OP_W'(4);
   localparam logic [OP_W-1:0] OP_XOR  = OP_W'(5);
   localparam logic [OP_W-1:0] OP_OR   = OP_W'(6);
   localparam logic [OP_W-1:0] OP_AND  = OP_W'(7);
   localparam logic [OP_W-1:0] OP_SLT  = OP_W'(8);
   localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(9);
   localparam logic [OP_W-1:0] OP_BNE  = OP_W'(10);
   localparam logic [OP_W-1:0] OP_BLT  = OP_W'(11);
   localparam logic [OP_W-1:0] OP_BGE  = OP_W'(12);
   localparam logic [OP_W-1:0] OP_SLTU = OP_W'(13);
   localparam logic [OP_W-1:0] OP_BLTU = OP_W'(14);
   localparam logic [OP_W-1:0] OP_BGEU = OP_W'(16);
`ifdef ALU_MC_MUL_EN
   localparam logic [OP_W-1:0] OP_MUL  = OP_W'(17);
`endif

`ifdef ALU_MC_MUL_EN
   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE, S_MUL} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
`endif

   state_t           state;
   logic [OP_W-1:0]  op_q;
   logic [XLEN-1:0]  acc;
   logic [CNT_W-1:0] cnt;

   logic [XLEN-1:0]  alu_c;
   logic             br_c;
   logic [SH_W-1:0]  shamt;
   logic             is_shift;
   logic [CNT_W-1:0] step_amt;
   logic [XLEN-1:0]  shift_nxt;

   assign shamt    = bus.operand_b[SH_W-1:0];
   assign is_shift = (bus.alu_ops == OP_SLL) || (bus.alu_ops == OP_SRL) ||
                     (bus.alu_ops == OP_SRA);

   // Single-cycle result. Shifts only reach this path with a zero amount,
   // so their result is operand_a unchanged.
   always_comb begin
      alu_c = '0;
      br_c  = 1'b0;
      case (bus.alu_ops)
         OP_ADD:  alu_c = bus.operand_a + bus.operand_b;
         OP_SUB:  alu_c = bus.operand_a - bus.operand_b;
         OP_SLL,
         OP_SRL,
         OP_SRA:  alu_c = bus.operand_a;
         OP_XOR:  alu_c = bus.operand_a ^ bus.operand_b;
         OP_OR:   alu_c = bus.operand_a | bus.operand_b;
         OP_AND:  alu_c = bus.operand_a & bus.operand_b;
         OP_SLT:  alu_c = {{(XLEN-1){1'b0}},
                           ($signed(bus.operand_a) < $signed(bus.operand_b))};
         OP_SLTU: alu_c = {{(XLEN-1){1'b0}}, (bus.operand_a < bus.operand_b)};
         OP_BEQ:  br_c  = (bus.operand_a == bus.operand_b);
         OP_BNE:  br_c  = (bus.operand_a != bus.operand_b);
         OP_BLT:  br_c  = ($signed(bus.operand_a) <  $signed(bus.operand_b));
         OP_BGE:  br_c  = ($signed(bus.operand_a) >= $signed(bus.operand_b));
         OP_BLTU: br_c  = (bus.operand_a <  bus.operand_b);
         OP_BGEU: br_c  = (bus.operand_a >= bus.operand_b);
         default: ;
      endcase
   end

   // One shifter iteration: min(SHIFT_STEP, remaining) positions.
   always_comb begin
      step_amt = (cnt < CNT_W'(SHIFT_STEP)) ? cnt : CNT_W'(SHIFT_STEP);
      case (op_q)
         OP_SLL:  shift_nxt = acc << step_amt;
         OP_SRL:  shift_nxt = acc >> step_amt;
         default: shift_nxt = $unsigned($signed(acc) >>> step_amt);
      endcase
   end

`ifdef ALU_MC_MUL_EN
   logic [XLEN-1:0] mcand;
   logic [XLEN-1:0] mplier;
   logic [XLEN-1:0] mul_nxt;

   // Consume SHIFT_STEP multiplier bits; only the low XLEN product bits are kept.
   always_comb begin
      mul_nxt = acc;
      for (int i = 0; i < SHIFT_STEP; i++) begin
         if (mplier[i])
            mul_nxt = mul_nxt + (mcand << i);
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state             <= S_IDLE;
         op_q              <= '0;
         acc               <= '0;
         cnt               <= '0;
         bus.in_ready      <= 1'b1;
         bus.out_valid     <= 1'b0;
         bus.alu_output    <= '0;
         bus.branch_output <= 1'b0;
         bus.busy          <= 1'b0;
`ifdef ALU_MC_MUL_EN
         mcand             <= '0;
         mplier            <= '0;
`endif
      end else if (bus.flush) begin
         state             <= S_IDLE;
         cnt               <= '0;
         bus.in_ready      <= 1'b1;
         bus.out_valid     <= 1'b0;
         bus.alu_output    <= '0;
         bus.branch_output <= 1'b0;
         bus.busy          <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  op_q         <= bus.alu_ops;
                  bus.in_ready <= 1'b0;
                  if (is_shift && (shamt != '0)) begin
                     acc      <= bus.operand_a;
                     cnt      <= {1'b0, shamt};
                     bus.busy <= 1'b1;
                     state    <= S_SHIFT;
                  end
`ifdef ALU_MC_MUL_EN
                  else if (bus.alu_ops == OP_MUL) begin
                     acc      <= '0;
                     mcand    <= bus.operand_a;
                     mplier   <= bus.operand_b;
                     cnt      <= CNT_W'(XLEN / SHIFT_STEP);
                     bus.busy <= 1'b1;
                     state    <= S_MUL;
                  end
`endif
                  else begin
                     bus.alu_output    <= alu_c;
                     bus.branch_output <= br_c;
                     bus.out_valid     <= 1'b1;
                     state             <= S_DONE;
                  end
               end
            end
            S_SHIFT: begin
               acc <= shift_nxt;
               cnt <= cnt - step_amt;
               if (cnt == step_amt) begin
                  bus.alu_output    <= shift_nxt;
                  bus.branch_output <= 1'b0;
                  bus.out_valid     <= 1'b1;
                  bus.busy          <= 1'b0;
                  state             <= S_DONE;
               end
            end
`ifdef ALU_MC_MUL_EN
            S_MUL: begin
               acc    <= mul_nxt;
               mcand  <= mcand << SHIFT_STEP;
               mplier <= mplier >> SHIFT_STEP;
               cnt    <= cnt - 1'b1;
               if (cnt == CNT_W'(1)) begin
                  bus.alu_output    <= mul_nxt;
                  bus.branch_output <= 1'b0;
                  bus.out_valid     <= 1'b1;
                  bus.busy          <= 1'b0;
                  state             <= S_DONE;
               end
            end
`endif
            S_DONE: begin
               if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
                  bus.in_ready  <= 1'b1;
                  state         <= S_IDLE;
               end
            end
            default: begin
               bus.in_ready  <= 1'b1;
               bus.out_valid <= 1'b0;
               bus.busy      <= 1'b0;
               state         <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mc.sv
// ----------------------------------------------------------------------------
// tb_alu_mc : self-checking bench for alu_mc (XLEN=32, SHIFT_STEP=1).
// Directed steps followed by randomized operations, each compared with an
// arithmetic reference model.
// ----------------------------------------------------------------------------
module tb_alu_mc;

   localparam int XLEN       = 32;
   localparam int SHIFT_STEP = 1;
   localparam int OP_W       = 5;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_bad;

   alu_mc_if #(.XLEN(XLEN), .OP_W(OP_W)) bus ();

   alu_mc #(.XLEN(XLEN), .SHIFT_STEP(SHIFT_STEP), .OP_W(OP_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog expired: observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] observed,
                        input logic [63:0] expected);
      n_cmp++;
      assert (observed === expected) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Reference: {branch, result} straight from the opcode definitions.
   function automatic logic [32:0] model(input int op, input logic [31:0] a,
                                         input logic [31:0] b);
      logic [31:0] r;
      logic        br;
      int          sh;
      r  = 32'h0;
      br = 1'b0;
      sh = int'(b % 32);
      case (op)
         0:  r = a + b;
         1:  r = a - b;
         2:  r = a << sh;
         3:  r = a >> sh;
         4:  r = $signed(a) >>> sh;
         5:  r = a ^ b;
         6:  r = a | b;
         7:  r = a & b;
         8:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         13: r = (a < b) ? 32'd1 : 32'd0;
         9:  br = (a == b);
         10: br = (a != b);
         11: br = ($signed(a) < $signed(b));
         12: br = ($signed(a) >= $signed(b));
         14: br = (a < b);
         16: br = (a >= b);
`ifdef ALU_MC_MUL_EN
         17: r = a * b;
`endif
         default: ;
      endcase
      return {br, r};
   endfunction

   function automatic int model_latency(input int op, input logic [31:0] b);
      int sh;
      sh = int'(b % 32);
      if ((op == 2 || op == 3 || op == 4) && sh != 0)
         return 1 + (sh + SHIFT_STEP - 1) / SHIFT_STEP;
`ifdef ALU_MC_MUL_EN
      if (op == 17)
         return 1 + XLEN / SHIFT_STEP;
`endif
      return 1;
   endfunction

   // Issue one op at a negedge, scramble inputs after accept, measure
   // latency/busy, hold the result for 'hold' cycles, then consume it.
   task automatic run_op(input string tag, input int op, input logic [31:0] a,
                         input logic [31:0] b, input int hold);
      logic [32:0] exp;
      int          lat;
      int          busy_cnt;
      int          exp_lat;
      exp     = model(op, a, b);
      exp_lat = model_latency(op, b);
      check({tag, ".in_ready_idle"}, 64'(bus.in_ready), 64'd1);
      bus.alu_ops   = OP_W'(op);
      bus.operand_a = a;
      bus.operand_b = b;
      bus.in_valid  = 1'b1;
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.alu_ops   = OP_W'($urandom_range(0, 31));
      bus.operand_a = $urandom;
      bus.operand_b = $urandom;
      lat      = 1;
      busy_cnt = 0;
      while (!bus.out_valid && lat < 200) begin
         if (bus.busy) busy_cnt++;
         @(negedge clk);
         lat++;
      end
      check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
      check({tag, ".busy_cycles"}, 64'(busy_cnt), 64'(exp_lat - 1));
      check({tag, ".alu_output"}, 64'(bus.alu_output), 64'(exp[31:0]));
      check({tag, ".branch_output"}, 64'(bus.branch_output), 64'(exp[32]));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check({tag, ".hold_alu"}, 64'(bus.alu_output), 64'(exp[31:0]));
         check({tag, ".hold_valid"}, 64'(bus.out_valid), 64'd1);
         check({tag, ".hold_in_ready"}, 64'(bus.in_ready), 64'd0);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check({tag, ".release_valid"}, 64'(bus.out_valid), 64'd0);
      check({tag, ".release_in_ready"}, 64'(bus.in_ready), 64'd1);
   endtask

   int ops_tbl[18] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16, 17};

   initial begin
      int seen;
      int op;
      logic [31:0] ra;
      logic [31:0] rb;
      n_cmp = 0;
      n_bad = 0;

      // Reset held with a pending request.
      rst_n         = 1'b0;
      bus.flush     = 1'b0;
      bus.in_valid  = 1'b1;
      bus.alu_ops   = OP_W'(0);
      bus.operand_a = 32'd1;
      bus.operand_b = 32'd2;
      bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("reset.in_ready", 64'(bus.in_ready), 64'd1);
      check("reset.out_valid", 64'(bus.out_valid), 64'd0);
      check("reset.alu_output", 64'(bus.alu_output), 64'd0);
      check("reset.branch_output", 64'(bus.branch_output), 64'd0);
      check("reset.busy", 64'(bus.busy), 64'd0);
      bus.in_valid = 1'b0;
      rst_n        = 1'b1;
      @(negedge clk);

      run_op("add", 0, 32'd5, 32'd7, 0);
      run_op("or", 6, 32'hF0, 32'h0F, 0);
      run_op("and", 7, 32'hF0, 32'h0F, 0);
      run_op("slt", 8, 32'hFFFF_FFFF, 32'd1, 0);
      run_op("sltu", 13, 32'hFFFF_FFFF, 32'd1, 0);
      run_op("bgeu", 16, 32'hFFFF_FFFF, 32'd1, 0);
      run_op("bltu", 14, 32'd1, 32'hFFFF_FFFF, 0);
      run_op("sra31", 4, 32'h8000_0000, 32'd31, 0);
      run_op("sll0", 2, 32'h1234_5678, 32'h20, 0);
      run_op("sub_bp", 1, 32'd3, 32'd5, 5);
      run_op("op17", 17, 32'h1_0000, 32'h1_0001, 0);
      run_op("nop", 15, 32'hDEAD_BEEF, 32'h1, 1);
      run_op("unk", 25, 32'hDEAD_BEEF, 32'h1, 0);

      // Flush mid-shift: no result must ever appear.
      bus.alu_ops   = OP_W'(2);
      bus.operand_a = 32'h0000_0003;
      bus.operand_b = 32'd20;
      bus.in_valid  = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("flush.busy_before", 64'(bus.busy), 64'd1);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      check("flush.in_ready", 64'(bus.in_ready), 64'd1);
      check("flush.busy", 64'(bus.busy), 64'd0);
      check("flush.alu_output", 64'(bus.alu_output), 64'd0);
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         if (bus.out_valid) seen++;
         @(negedge clk);
      end
      check("flush.no_out_valid", 64'(seen), 64'd0);

      // Flush beats a simultaneous accept.
      bus.alu_ops   = OP_W'(0);
      bus.operand_a = 32'd9;
      bus.operand_b = 32'd9;
      bus.in_valid  = 1'b1;
      bus.flush     = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.flush    = 1'b0;
      @(negedge clk);
      check("flush_accept.out_valid", 64'(bus.out_valid), 64'd0);
      check("flush_accept.in_ready", 64'(bus.in_ready), 64'd1);
      run_op("after_flush_add", 0, 32'd100, 32'd23, 0);

      // Asynchronous reset in the middle of a shift.
      bus.alu_ops   = OP_W'(3);
      bus.operand_a = 32'hFFFF_0000;
      bus.operand_b = 32'd10;
      bus.in_valid  = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midreset.busy", 64'(bus.busy), 64'd0);
      check("midreset.in_ready", 64'(bus.in_ready), 64'd1);
      check("midreset.out_valid", 64'(bus.out_valid), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_op("after_reset_xor", 5, 32'hAAAA_5555, 32'hFFFF_0000, 0);

      // Randomized operations.
      for (int n = 0; n < 150; n++) begin
         if ($urandom_range(0, 7) == 0)
            op = int'($urandom_range(0, 31));
         else
            op = ops_tbl[$urandom_range(0, 17)];
         ra = $urandom;
         rb = $urandom;
         if ($urandom_range(0, 3) == 0) rb = ra;
         run_op("rand", op, ra, rb, int'($urandom_range(0, 3)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
